sws_switch_sequencer: RTL and testbench
=======================================

# sws_switch_sequencer

Break-before-make sequencer for the on-die analog switch bank that routes the internal analog nodes onto the ua[5:0] pads. It accepts manual channel-select requests from the digital inputs, or autonomously scans a mask of channels with a programmable dwell time. It guarantees that no two switches are ever closed in the same cycle, and that a dead interval of all switches open precedes every closure.

## Interface
Parameters:
- NUM_SW, 6: number of analog switches/channels (legal range 1..7).
- DEAD_CYCLES, 4: all-open cycles before any closure (minimum 1).
- DWELL_W, 8: width of the dwell input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  manual channel request valid.
- req_ch  in  3  requested channel; any value >= NUM_SW means "all open".
- req_ready  out  1  request accepted when req_valid && req_ready.
- scan_en  in  1  1 = auto-scan mode; manual requests are blocked.
- scan_mask  in  NUM_SW  channels included in the scan.
- dwell  in  DWELL_W  closed time per scan channel, in cycles (0 is treated as 1).
- sw_on  out  NUM_SW  switch gate drives, one-hot or zero, registered.
- cur_ch  out  3  index of the closed channel; 7 when all are open.
- make_pulse  out  1  one-cycle pulse in the first cycle of each closure.
- busy  out  1  high in BREAK.

## Operation
- FSM states: OFF (all open, idle), BREAK (all open, dead counter running), ON (exactly one switch closed). Registers: state, target, cur_ch, dead counter, dwell counter, scan pointer.
- OFF:
  - Scan mode (scan_en=1, scan_mask!=0): target = first set mask bit at or after the scan pointer, with wrap-around. Go to BREAK.
  - Manual mode: on an accepted request with req_ch<NUM_SW, target=req_ch and go to BREAK. On an accepted request with an invalid req_ch, stay in OFF.
- BREAK:
  - Dead counter loads DEAD_CYCLES-1 on entry and decrements each cycle.
  - At 0: go to ON, sw_on=onehot(target), cur_ch=target, make_pulse=1. The dwell counter loads max(dwell,1)-1.
- ON, manual mode:
  - Accepted req_ch==cur_ch: stay in ON, no glitch, no make_pulse.
  - Accepted valid req_ch with a different channel: go to BREAK with the new target.
  - Accepted invalid req_ch: go to OFF.
- ON, scan mode:
  - The dwell counter decrements each cycle. At 0, advance to the next set mask bit above cur_ch, wrapping to the lowest.
  - If the next channel differs from cur_ch, go to BREAK. If the mask has only cur_ch set, stay in ON, reload dwell, and emit no make_pulse.
  - The scan pointer is updated to next+1 (mod NUM_SW).
- Forced open: in ON, if scan_en rises or falls, or the current bit of scan_mask clears while scanning, go to OFF next cycle. Opening needs no dead time.
- In BREAK, scan_mask becoming 0 or scan_en changing aborts to OFF.
- req_ready = !scan_en && state!=BREAK.

## Timing
- Reset (async assert): sw_on=0, cur_ch=7, make_pulse=0, busy=0, req_ready=1 (if scan_en=0), state=OFF, scan pointer=0. Outputs clear immediately, without waiting for a clock edge.
- Request accepted at edge t: BREAK during cycles t+1..t+DEAD_CYCLES, with sw_on=0 and busy=1. sw_on is asserted from cycle t+DEAD_CYCLES+1, together with make_pulse.
- Switching from channel A to channel B: sw_on=0 from the cycle after acceptance. There are exactly DEAD_CYCLES all-open cycles before B closes.
- Scan: each channel is closed for max(dwell,1) cycles, followed by DEAD_CYCLES open cycles. Period per channel = max(dwell,1)+DEAD_CYCLES.
- dwell is sampled when each ON phase is entered. Changes mid-dwell take effect on the next closure.
- Invariant: popcount(sw_on) <= 1 in every cycle. sw_on never changes directly from one non-zero value to a different non-zero value.

## Test plan
- Reset, DEAD_CYCLES=4, req ch 2 accepted at t0 -> sw_on=0 for t1..t4, sw_on=000100 with make_pulse at t5, cur_ch=2, busy high t1..t4.
- ON at ch 2, req ch 5 -> sw_on=0 the next cycle, 4 open cycles, then 100000. An assertion checks one-hot-or-zero on every cycle. A repeated req ch 5 gives no glitch and no make_pulse.
- scan_en=1, mask=101001, dwell=3 -> closures ch0, ch3, ch5, ch0 (wrap). Each is closed 3 cycles with 4 open cycles between, and make_pulse fires on each closure.
- Scan with mask=000010, dwell=2 -> ch1 closes once and stays closed continuously. A single make_pulse. Clearing mask bit 1 gives sw_on=0 and cur_ch=7 the next cycle.
- ON at ch 3, req_ch=6 -> OFF the next cycle with no BREAK (busy stays 0). A new req ch 0 then goes through the full dead time.
- rst_n asserted asynchronously mid-BREAK and mid-ON -> sw_on=0 and cur_ch=7 with no clock edge. After release, the first scan starts at ch0.

Source files
------------

// File: rtl/sws_switch_sequencer.sv
// Break-before-make sequencer for the analog pad switch bank: manual channel select or
// masked auto-scan, with a guaranteed all-open dead interval before every closure.
module sws_switch_sequencer #(
    parameter int NUM_SW      = 6,
    parameter int DEAD_CYCLES = 4,
    parameter int DWELL_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [2:0]         req_ch,
    output logic               req_ready,
    input  logic               scan_en,
    input  logic [NUM_SW-1:0]  scan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NUM_SW-1:0]  sw_on,
    output logic [2:0]         cur_ch,
    output logic               make_pulse,
    output logic               busy
);

    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [2:0] CH_NONE = 3'd7;

    typedef enum logic [1:0] {ST_OFF, ST_BREAK, ST_ON} state_e;

    state_e              state_q, state_d;
    logic [2:0]          target_q, target_d;
    logic [2:0]          cur_ch_q, cur_ch_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [NUM_SW-1:0]   sw_on_q, sw_on_d;
    logic                make_pulse_q, make_pulse_d;
    logic                scan_en_q;

    logic                req_acc, req_ok, scan_chg;
    logic [3:0]          first_hit, next_hit;
    logic [DWELL_W-1:0]  dwell_load;

    // Returns {found, index} of the first set mask bit at or after start, wrapping.
    function automatic logic [3:0] first_from(input logic [NUM_SW-1:0] mask,
                                              input logic [2:0] start);
        logic [3:0] r;
        logic [2:0] idx3;
        int         idx;
        r = 4'd0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            idx = int'(start) + i;
            if (idx >= NUM_SW) idx = idx - NUM_SW;
            idx3 = 3'(idx);
            if (mask[idx3]) r = {1'b1, idx3};
        end
        return r;
    endfunction

    function automatic logic [2:0] inc_ch(input logic [2:0] ch);
        return (int'(ch) + 1 >= NUM_SW) ? 3'd0 : ch + 3'd1;
    endfunction

    assign req_ready  = !scan_en && (state_q != ST_BREAK);
    assign req_acc    = req_valid && req_ready;
    assign req_ok     = (int'(req_ch) < NUM_SW);
    assign scan_chg   = (scan_en != scan_en_q);
    assign dwell_load = (dwell == '0) ? '0 : dwell - 1'b1;
    assign first_hit  = first_from(scan_mask, ptr_q);
    // Search starts just above cur_ch, so cur_ch itself is the last candidate.
    assign next_hit   = first_from(scan_mask, inc_ch(cur_ch_q));

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        cur_ch_d     = cur_ch_q;
        ptr_d        = ptr_q;
        dead_d       = dead_q;
        dwell_d      = dwell_q;
        sw_on_d      = sw_on_q;
        make_pulse_d = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                if (scan_en) begin
                    if (first_hit[3]) begin
                        target_d = first_hit[2:0];
                        dead_d   = DEAD_LOAD;
                        state_d  = ST_BREAK;
                    end
                end else if (req_acc && req_ok) begin
                    target_d = req_ch;
                    dead_d   = DEAD_LOAD;
                    state_d  = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (scan_chg || (scan_en && scan_mask == '0)) begin
                    state_d = ST_OFF;
                end else if (dead_q == '0) begin
                    state_d      = ST_ON;
                    sw_on_d      = NUM_SW'(1) << target_q;
                    cur_ch_d     = target_q;
                    make_pulse_d = 1'b1;
                    dwell_d      = dwell_load;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            ST_ON: begin
                // Opening never needs dead time, so forced opens go straight to OFF.
                if (scan_chg || (scan_en && !scan_mask[cur_ch_q])) begin
                    state_d  = ST_OFF;
                    sw_on_d  = '0;
                    cur_ch_d = CH_NONE;
                end else if (scan_en) begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - 1'b1;
                    end else begin
                        ptr_d = inc_ch(next_hit[2:0]);
                        if (next_hit[3] && next_hit[2:0] != cur_ch_q) begin
                            target_d = next_hit[2:0];
                            dead_d   = DEAD_LOAD;
                            state_d  = ST_BREAK;
                            sw_on_d  = '0;
                            cur_ch_d = CH_NONE;
                        end else begin
                            dwell_d = dwell_load;
                        end
                    end
                end else if (req_acc) begin
                    if (!req_ok) begin
                        state_d  = ST_OFF;
                        sw_on_d  = '0;
                        cur_ch_d = CH_NONE;
                    end else if (req_ch != cur_ch_q) begin
                        target_d = req_ch;
                        dead_d   = DEAD_LOAD;
                        state_d  = ST_BREAK;
                        sw_on_d  = '0;
                        cur_ch_d = CH_NONE;
                    end
                end
            end
            default: begin
                state_d  = ST_OFF;
                sw_on_d  = '0;
                cur_ch_d = CH_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            target_q     <= '0;
            cur_ch_q     <= CH_NONE;
            ptr_q        <= '0;
            dead_q       <= '0;
            dwell_q      <= '0;
            sw_on_q      <= '0;
            make_pulse_q <= 1'b0;
            scan_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            cur_ch_q     <= cur_ch_d;
            ptr_q        <= ptr_d;
            dead_q       <= dead_d;
            dwell_q      <= dwell_d;
            sw_on_q      <= sw_on_d;
            make_pulse_q <= make_pulse_d;
            scan_en_q    <= scan_en;
        end
    end

    assign sw_on      = sw_on_q;
    assign cur_ch     = cur_ch_q;
    assign make_pulse = make_pulse_q;
    assign busy       = (state_q == ST_BREAK);

endmodule

// File: tb/tb_sws_switch_sequencer.sv
// Bench for sws_switch_sequencer: expected closures (channel, cycle) are queued as stimulus
// is driven and matched against each make_pulse; tasks also check per-cycle switch state.
module tb_sws_switch_sequencer;

    localparam int NUM_SW  = 6;
    localparam int DEAD    = 4;
    localparam int DWELL_W = 8;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b1;
    logic               req_valid = 1'b0;
    logic [2:0]         req_ch    = 3'd0;
    logic               scan_en   = 1'b0;
    logic [NUM_SW-1:0]  scan_mask = '0;
    logic [DWELL_W-1:0] dwell     = '0;
    logic               req_ready, make_pulse, busy;
    logic [NUM_SW-1:0]  sw_on;
    logic [2:0]         cur_ch;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    sws_switch_sequencer #(.NUM_SW(NUM_SW), .DEAD_CYCLES(DEAD), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ch(req_ch),
        .req_ready(req_ready), .scan_en(scan_en), .scan_mask(scan_mask), .dwell(dwell),
        .sw_on(sw_on), .cur_ch(cur_ch), .make_pulse(make_pulse), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Request accepted at the edge whose count is returned in s.
    task automatic send_req(input logic [2:0] ch, output int s);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_ch    = ch;
        @(posedge clk); #1;
        req_valid = 1'b0;
        s = cyc;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sw_on !== '0 || cur_ch !== 3'd7 || make_pulse !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async sw_on=%b cur_ch=%0d mp=%b busy=%b rdy=%b required 0/7/0/0/1",
                     sw_on, cur_ch, make_pulse, busy, req_ready);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sw_on !== '0 || cur_ch !== 3'd7 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle sw_on=%b cur_ch=%0d busy=%b required 0/7/0", sw_on, cur_ch, busy);
        end
    endtask

    task automatic test_manual();
        int s;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL manual_ready rdy=%b required 1", req_ready);
        end
        send_req(3'd2, s);
        exp_q.push_back('{ch: 2, cyc: s + DEAD});
        for (int i = 0; i < DEAD; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b1 || sw_on !== '0 || cur_ch !== 3'd7 || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL manual_break i=%0d busy=%b sw_on=%b cur_ch=%0d rdy=%b required 1/0/7/0",
                         i, busy, sw_on, cur_ch, req_ready);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (sw_on !== 6'b000100 || cur_ch !== 3'd2 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL manual_close sw_on=%b cur_ch=%0d busy=%b required 000100/2/0", sw_on, cur_ch, busy);
        end
    endtask

    task automatic test_switch();
        int s;
        send_req(3'd5, s);
        exp_q.push_back('{ch: 5, cyc: s + DEAD});
        for (int i = 0; i < DEAD; i++) begin
            @(negedge clk);
            n_cmp++;
            if (sw_on !== '0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL switch_open i=%0d sw_on=%b busy=%b required 0/1", i, sw_on, busy);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (sw_on !== 6'b100000 || cur_ch !== 3'd5) begin
            n_err++;
            $display("FAIL switch_close sw_on=%b cur_ch=%0d required 100000/5", sw_on, cur_ch);
        end
        send_req(3'd5, s);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (sw_on !== 6'b100000 || make_pulse !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL same_ch_hold i=%0d sw_on=%b mp=%b busy=%b required 100000/0/0",
                         i, sw_on, make_pulse, busy);
            end
        end
    endtask

    task automatic test_invalid_open();
        int s;
        send_req(3'd3, s);
        exp_q.push_back('{ch: 3, cyc: s + DEAD});
        repeat (DEAD + 1) @(negedge clk);
        n_cmp++;
        if (sw_on !== 6'b001000) begin
            n_err++;
            $display("FAIL inv_pre_close sw_on=%b required 001000", sw_on);
        end
        send_req(3'd6, s);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (sw_on !== '0 || cur_ch !== 3'd7 || busy !== 1'b0 || req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL inv_open i=%0d sw_on=%b cur_ch=%0d busy=%b rdy=%b required 0/7/0/1",
                         i, sw_on, cur_ch, busy, req_ready);
            end
        end
        send_req(3'd0, s);
        exp_q.push_back('{ch: 0, cyc: s + DEAD});
        for (int i = 0; i < DEAD; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b1 || sw_on !== '0) begin
                n_err++;
                $display("FAIL reopen_break i=%0d busy=%b sw_on=%b required 1/0", i, busy, sw_on);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (sw_on !== 6'b000001 || cur_ch !== 3'd0) begin
            n_err++;
            $display("FAIL reopen_close sw_on=%b cur_ch=%0d required 000001/0", sw_on, cur_ch);
        end
        send_req(3'd7, s);
        @(negedge clk);
        n_cmp++;
        if (sw_on !== '0 || cur_ch !== 3'd7) begin
            n_err++;
            $display("FAIL ch7_open sw_on=%b cur_ch=%0d required 0/7", sw_on, cur_ch);
        end
    endtask

    task automatic test_scan_multi();
        int s;
        int chs[4];
        logic [NUM_SW-1:0] exp_sw;
        chs = '{0, 3, 5, 0};
        @(posedge clk); #1;
        scan_mask = 6'b101001;
        dwell     = 8'd3;
        scan_en   = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        for (int k = 0; k < 4; k++) exp_q.push_back('{ch: chs[k], cyc: s + DEAD + k * (3 + DEAD)});
        for (int c = 0; c < 4 * (3 + DEAD); c++) begin
            @(negedge clk);
            exp_sw = (c % 7 >= DEAD) ? (NUM_SW'(1) << chs[c / 7]) : '0;
            n_cmp++;
            if (sw_on !== exp_sw || busy !== (c % 7 < DEAD) || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL scan_multi c=%0d sw_on=%b busy=%b rdy=%b required %b/%b/0",
                         c, sw_on, busy, req_ready, exp_sw, (c % 7 < DEAD));
            end
        end
        @(posedge clk); #1;
        scan_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || sw_on !== '0 || cur_ch !== 3'd7) begin
            n_err++;
            $display("FAIL scan_abort busy=%b sw_on=%b cur_ch=%0d required 0/0/7", busy, sw_on, cur_ch);
        end
    endtask

    task automatic test_scan_single();
        int s;
        logic [NUM_SW-1:0] exp_sw;
        @(posedge clk); #1;
        scan_mask = 6'b000010;
        dwell     = 8'd2;
        scan_en   = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        exp_q.push_back('{ch: 1, cyc: s + DEAD});
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_sw = (c >= DEAD) ? 6'b000010 : 6'b000000;
            n_cmp++;
            if (sw_on !== exp_sw) begin
                n_err++;
                $display("FAIL scan_single c=%0d sw_on=%b required %b", c, sw_on, exp_sw);
            end
        end
        @(posedge clk); #1;
        scan_mask = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sw_on !== '0 || cur_ch !== 3'd7 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mask_clear sw_on=%b cur_ch=%0d busy=%b required 0/7/0", sw_on, cur_ch, busy);
        end
        @(posedge clk); #1;
        scan_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int s;
        int chs[3];
        logic [NUM_SW-1:0] exp_sw;
        chs = '{0, 3, 5};
        send_req(3'd4, s);
        exp_q.push_back('{ch: 4, cyc: s + DEAD});
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sw_on !== '0 || cur_ch !== 3'd7 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_break sw_on=%b cur_ch=%0d busy=%b required 0/7/0", sw_on, cur_ch, busy);
        end
        exp_q.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        send_req(3'd4, s);
        exp_q.push_back('{ch: 4, cyc: s + DEAD});
        repeat (DEAD + 1) @(negedge clk);
        n_cmp++;
        if (sw_on !== 6'b010000) begin
            n_err++;
            $display("FAIL pre_rst_on sw_on=%b required 010000", sw_on);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sw_on !== '0 || cur_ch !== 3'd7 || make_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_on sw_on=%b cur_ch=%0d mp=%b required 0/7/0", sw_on, cur_ch, make_pulse);
        end
        exp_q.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        // Scan with dwell=0 behaves as dwell=1, and must restart from channel 0.
        @(posedge clk); #1;
        scan_mask = 6'b101001;
        dwell     = 8'd0;
        scan_en   = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        for (int k = 0; k < 3; k++) exp_q.push_back('{ch: chs[k], cyc: s + DEAD + k * (1 + DEAD)});
        for (int c = 0; c < 3 * (1 + DEAD); c++) begin
            @(negedge clk);
            exp_sw = (c % 5 == DEAD) ? (NUM_SW'(1) << chs[c / 5]) : '0;
            n_cmp++;
            if (sw_on !== exp_sw) begin
                n_err++;
                $display("FAIL scan_after_rst c=%0d sw_on=%b required %b", c, sw_on, exp_sw);
            end
        end
        @(posedge clk); #1;
        scan_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sw_on !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL final_off sw_on=%b busy=%b required 0/0", sw_on, busy);
        end
    endtask

    task automatic check_drained(input string tag);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_pending closures_left=%0d required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        fork
            begin : monitor
                logic [NUM_SW-1:0] prev_sw;
                exp_t e;
                prev_sw = '0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        prev_sw = '0;
                    end else begin
                        n_cmp++;
                        if ($countones(sw_on) > 1 || (prev_sw != '0 && sw_on != '0 && sw_on != prev_sw)) begin
                            n_err++;
                            $display("FAIL bbm_invariant cyc=%0d sw_on=%b prev=%b required one-hot-or-zero via zero",
                                     cyc, sw_on, prev_sw);
                        end
                        prev_sw = sw_on;
                        if (make_pulse === 1'b1) begin
                            n_cmp++;
                            if (exp_q.size() == 0) begin
                                n_err++;
                                $display("FAIL unexpected_make cyc=%0d cur_ch=%0d required no pulse", cyc, cur_ch);
                            end else begin
                                e = exp_q.pop_front();
                                if (cur_ch !== 3'(e.ch) || cyc != e.cyc || sw_on !== (NUM_SW'(1) << e.ch)) begin
                                    n_err++;
                                    $display("FAIL closure cyc=%0d ch=%0d sw_on=%b required cyc=%0d ch=%0d",
                                             cyc, cur_ch, sw_on, e.cyc, e.ch);
                                end
                            end
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_manual();
        check_drained("manual");
        test_switch();
        check_drained("switch");
        test_invalid_open();
        check_drained("invalid");
        test_scan_multi();
        check_drained("scan_multi");
        test_scan_single();
        check_drained("scan_single");
        test_async_reset();
        check_drained("async_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
